// File: rtl/page_scrambler_ctrl_pkg.sv
// page_scrambler_ctrl_pkg: state encoding and constants shared by the page scrambler sequencer
package page_scrambler_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int LEN_W_DEFAULT = 14;
  localparam logic [7:0] BYPASS_KEY = 8'h00;
endpackage

// File: rtl/page_scrambler_ctrl_lfsr8.sv
// page_scrambler_ctrl_lfsr8: 9-bit-state LFSR producing the 8-bit scrambling key
module page_scrambler_ctrl_lfsr8 (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iSeed,
  input  logic       iSeedEnable,
  input  logic       iShiftEnable,
  output logic [7:0] oData
);
  logic [8:0] r;
  always_ff @(posedge iClock)
    if (iReset) r <= '0;
    else if (iSeedEnable) r <= {iSeed, iSeed[0] ^ iSeed[4] ^ iSeed[5] ^ iSeed[6]};
    else if (iShiftEnable) r <= {r[7:0], r[0] ^ r[4] ^ r[5] ^ r[6] ^ r[8]};
  assign oData = r[7:0];
endmodule

// File: rtl/page_scrambler_ctrl.sv
// page_scrambler_ctrl: per-page LFSR scramble/descramble sequencer between channel and page buffer
module page_scrambler_ctrl
  import page_scrambler_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [7:0]       iCmdSeed,
  input  logic [LEN_W-1:0] iCmdLength,
  input  logic             iCmdBypass,
  input  logic             iAbort,
  input  logic             iDataValid,
  output logic             oDataReady,
  input  logic [7:0]       iData,
  output logic             oDataValid,
  input  logic             iDataReady,
  output logic [7:0]       oData,
  output logic             oDataLast,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDoneAborted
);
  state_t state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic [7:0] key;
  logic bypass, aborted, cmd_acc, in_acc, consume, abort_act, final_acc;

  page_scrambler_ctrl_lfsr8 u_lfsr (
    .iClock      (iClock),
    .iReset      (iReset),
    .iSeed       (iCmdSeed),
    .iSeedEnable (cmd_acc),
    .iShiftEnable(in_acc),
    .oData       (key)
  );

  assign oCmdReady    = state == IDLE && !iReset;
  assign cmd_acc      = iCmdValid && oCmdReady;
  assign abort_act    = iAbort && (state == RUN || state == DRAIN);
  // abort wins over a same-cycle byte, so the input handshake is withheld
  assign oDataReady   = state == RUN && !iAbort && (!oDataValid || iDataReady);
  assign in_acc       = iDataValid && oDataReady;
  assign consume      = oDataValid && iDataReady;
  assign final_acc    = in_acc && remaining == LEN_W'(1);
  assign oBusy        = state != IDLE;
  assign oDone        = state == DONE;
  assign oDoneAborted = oDone && aborted;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = cmd_acc ? (iCmdLength == '0 ? DONE : RUN) : IDLE;
      RUN:     state_nx = abort_act ? DONE : final_acc ? DRAIN : RUN;
      DRAIN:   state_nx = (abort_act || consume) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= IDLE;
      remaining  <= '0;
      bypass     <= 1'b0;
      aborted    <= 1'b0;
      oDataValid <= 1'b0;
      oData      <= '0;
      oDataLast  <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_acc) begin
        remaining <= iCmdLength;
        bypass    <= iCmdBypass;
        aborted   <= 1'b0;
      end else if (in_acc) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (abort_act) begin
        aborted    <= 1'b1;
        oDataValid <= 1'b0;
        oData      <= '0;
        oDataLast  <= 1'b0;
      end else if (in_acc) begin
        oDataValid <= 1'b1;
        oData      <= iData ^ (bypass ? BYPASS_KEY : key);
        oDataLast  <= final_acc;
      end else if (consume) begin
        oDataValid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/page_scrambler_ctrl.md
# page_scrambler_ctrl

Sequences the team's 8-bit LFSR (LFSR8) to scramble or descramble one NAND page per command. It sits between the channel data path and the page buffer. Per command it loads a per-page seed, streams a fixed number of bytes through a one-deep registered stage XORed with the LFSR key, and reports completion. Scrambling and descrambling are the same operation.

## Interface
- LEN_W, 14: width of the byte-count field; max page = 2^LEN_W-1 bytes.
- iClock in 1: clock.
- iReset in 1: reset iReset, synchronous, active-high; clock iClock.
- iCmdValid in 1 / oCmdReady out 1: command handshake; transfer when both are high on a rising edge.
- iCmdSeed in 8: page seed.
- iCmdLength in LEN_W: byte count (0 legal).
- iCmdBypass in 1: 1 forces key 0 (plain pass-through).
- iAbort in 1: terminate the current page.
- iDataValid in 1 / oDataReady out 1 / iData in 8: input byte stream.
- oDataValid out 1 / iDataReady in 1 / oData out 8 / oDataLast out 1: output byte stream.
- oBusy out 1: high in any state but IDLE.
- oDone out 1: one-cycle completion pulse.
- oDoneAborted out 1: qualifies oDone; 1 means the page was aborted.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: oCmdReady=1. On command accept, drive LFSR iSeedEnable=1 with iCmdSeed and latch length and bypass.
  - Length 0 goes to DONE.
  - Otherwise go to RUN.
- LFSR model:
  - Seed load gives r[8:0]={seed, seed[0]^seed[4]^seed[5]^seed[6]}.
  - Each shift gives r={r[7:0], r[0]^r[4]^r[5]^r[6]^r[8]}.
  - The key is r[7:0].
  - Byte n (0-based) uses the key after n shifts from the load.
- RUN:
  - oDataReady = (output register empty) or (oDataValid and iDataReady).
  - An input accept (iDataValid and oDataReady) does three things:
    - The output register loads iData XOR key, or iData when bypass is set.
    - The LFSR shifts once (iShiftEnable). It shifts in bypass too.
    - The remaining count decrements.
  - oDataLast is set on the register entry holding the final byte.
  - After the final byte is accepted, go to DRAIN. oDataReady stays 0 outside RUN.
- DRAIN: hold the output until consumed, then go to DONE.
- DONE: oDone=1 for one cycle, then go to IDLE.
- Abort: iAbort in RUN or DRAIN does three things:
  - It clears the output register; the byte is dropped and not presented.
  - It suppresses shifting in that cycle.
  - It goes to DONE with oDoneAborted=1.
  - iAbort in IDLE or DONE is ignored.
- Simultaneous events:
  - Abort has priority over an accept in the same cycle; that byte is not consumed.
  - A consume and a fresh accept in the same RUN cycle are both legal, giving full throughput.
- Seed 0x00 gives key 0 forever; this is legal and not flagged.
- Counter: remaining = length, decrements per accept, and never wraps. The final byte is at remaining==1.

## Timing
- Reset values: oCmdReady=0 during reset and 1 in the first cycle after it. oDataReady=0, oDataValid=0, oData=0, oDataLast=0, oBusy=0, oDone=0, oDoneAborted=0. LFSR=0. State=IDLE.
- Reset mid-page: all state is cleared in one cycle, with no oDone.
- Command accept to first oDataReady: 1 cycle.
- Input accept to oDataValid: 1 cycle (registered).
- Sustained rate: 1 byte per cycle when iDataValid and iDataReady are held high.
- Final output consume at edge t: oDone is high in cycle t+1, and oCmdReady is high in cycle t+2.
- Length 0: oDone is 1 cycle after command accept.
- oDataValid/oData/oDataLast are held stable while oDataValid=1 and iDataReady=0.

## Structure
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE), default LEN_W, and BYPASS_KEY=8'h00.
- Sub-module: one LFSR8 instance, driven only by this FSM (iSeed, iSeedEnable, iShiftEnable); its oData is the key.
- The rest is the FSM, the down-counter, and the output register, all in one module.

## Test plan
- Seed 0x01, length 5, input 00×5, iDataReady=1 -> output 03,07,0F,1F,3E. oDataLast on 3E. oDone 1 cycle after 3E consumed, oDoneAborted=0.
- Same command with input 03,07,0F,1F,3E -> output 00×5 (round trip).
- iCmdBypass=1, seed 0x5A, length 3, input A1,B2,C3 -> output A1,B2,C3 unchanged.
- Length 4, iDataReady held low for 3 cycles after byte 1 -> byte 1 held stable, oDataReady=0, no byte lost or duplicated. Output equals the no-stall run.
- Length 0 -> oDone 1 cycle after accept, no oDataValid. Then abort in RUN after 2 of 6 bytes -> oDone with oDoneAborted=1, no further oDataValid, oCmdReady back 1 cycle later.
- iReset asserted mid-page after 3 bytes -> all outputs at reset values next cycle. A new command with seed 0x01 then yields key 03 first.
